// File: rtl/seven_seg_bcd_timer_mux.sv
// N-digit BCD up/down timer with a programmable prescaler and a time-multiplexed
// seven-segment scan. Count, tick and wrap move together; display outputs lag count by one cycle.
module seven_seg_bcd_timer_mux #(
    parameter int NUM_DIGITS  = 2,
    parameter int DIV_W       = 24,
    parameter int REFRESH_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [DIV_W-1:0]        tick_div,
    input  logic [1:0]              mode,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tick,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);
    localparam int REF_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef logic [NUM_DIGITS-1:0][3:0] bcd_t;

    bcd_t               cnt_q, cnt_d, cnt_inc, cnt_dec, ld_sat;
    logic               inc_co, dec_bo;
    logic [DIV_W-1:0]   pre_q, pre_d;
    logic               step;
    logic               tick_q, tick_d, wrap_q, wrap_d, tog_q, tog_d;
    logic [REF_W-1:0]   ref_q, ref_d;
    logic               ref_end;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // The >= compare makes a shrinking tick_div fire on the next edge instead of overflowing.
    always_comb begin
        step   = ena && (pre_q >= tick_div);
        pre_d  = pre_q;
        if (ena) pre_d = step ? '0 : pre_q + 1'b1;
        tick_d = step;
        tog_d  = tog_q ^ step;
    end

    // Ripple carry/borrow across digits; a carry (borrow) out of the top digit is a roll-over.
    always_comb begin
        cnt_inc = cnt_q;
        cnt_dec = cnt_q;
        ld_sat  = bcd_t'(load_val);
        inc_co  = 1'b1;
        dec_bo  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (inc_co) begin
                if (cnt_q[i] == 4'd9) cnt_inc[i] = 4'd0;
                else begin
                    cnt_inc[i] = cnt_q[i] + 4'd1;
                    inc_co     = 1'b0;
                end
            end
            if (dec_bo) begin
                if (cnt_q[i] == 4'd0) cnt_dec[i] = 4'd9;
                else begin
                    cnt_dec[i] = cnt_q[i] - 4'd1;
                    dec_bo     = 1'b0;
                end
            end
            if (ld_sat[i] > 4'd9) ld_sat[i] = 4'd9;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = ld_sat;
        end else if (mode == 2'b11) begin
            cnt_d = '0;
        end else if (step) begin
            case (mode)
                2'b00: begin cnt_d = cnt_inc; wrap_d = inc_co; end
                2'b01: begin cnt_d = cnt_dec; wrap_d = dec_bo; end
                default: ;
            endcase
        end
    end

    always_comb begin
        ref_end = (ref_q == REF_W'(REFRESH_CYC - 1));
        ref_d   = ref_end ? '0 : ref_q + 1'b1;
        idx_d   = idx_q;
        if (ref_end) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        an_d  = NUM_DIGITS'(1) << idx_q;
        seg_d = seg_decode(cnt_q[idx_q]);
        dp_d  = tog_q && (idx_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            tog_q  <= 1'b0;
            ref_q  <= '0;
            idx_q  <= '0;
            an_q   <= NUM_DIGITS'(1);
            seg_q  <= 7'h3F;
            dp_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            tog_q  <= tog_d;
            ref_q  <= ref_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign count = cnt_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;
    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
endmodule

// File: tb/tb_seven_seg_bcd_timer_mux.sv
// Directed bench for seven_seg_bcd_timer_mux: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares the ones due on that cycle.
module tb_seven_seg_bcd_timer_mux;
    localparam int ND = 2;
    localparam int DW = 8;
    localparam int RC = 4;

    localparam int K_CNT = 0, K_TICK = 1, K_WRAP = 2, K_SEG = 3, K_AN = 4, K_DP = 5;

    logic            clk = 1'b0;
    logic            rst, ena, load;
    logic [DW-1:0]   tick_div;
    logic [1:0]      mode;
    logic [4*ND-1:0] load_val, count;
    logic            tick, wrap, dp;
    logic [6:0]      seg;
    logic [ND-1:0]   an;

    seven_seg_bcd_timer_mux #(.NUM_DIGITS(ND), .DIV_W(DW), .REFRESH_CYC(RC)) dut (
        .clk(clk), .rst(rst), .ena(ena), .tick_div(tick_div), .mode(mode),
        .load(load), .load_val(load_val), .count(count), .tick(tick),
        .wrap(wrap), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] v;
    } exp_t;

    exp_t sbq[$];
    exp_t keep_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_CNT:   return "count";
            K_TICK:  return "tick";
            K_WRAP:  return "wrap";
            K_SEG:   return "seg";
            K_AN:    return "an";
            default: return "dp";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_CNT:   return 32'(count);
            K_TICK:  return 32'(tick);
            K_WRAP:  return 32'(wrap);
            K_SEG:   return 32'(seg);
            K_AN:    return 32'(an);
            default: return 32'(dp);
        endcase
    endfunction

    // Expectation due k rising edges from now, checked on the following falling edge.
    task automatic ex(input int k, input int kind, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc + k;
        e.kind = kind;
        e.v = v;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        keep_q = {};
        foreach (sbq[i]) begin
            if (sbq[i].cyc == cyc) begin
                total++;
                if (actual(sbq[i].kind) !== sbq[i].v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%0h want=%0h", kname(sbq[i].kind), cyc,
                             actual(sbq[i].kind), sbq[i].v);
                end
            end else if (sbq[i].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s missed cyc=%0d want=%0h", kname(sbq[i].kind), sbq[i].cyc, sbq[i].v);
            end else begin
                keep_q.push_back(sbq[i]);
            end
        end
        sbq = keep_q;
    end

    task automatic rst_cyc();
        rst = 1'b1;
        load = 1'b0;
        ena = 1'b0;
        mode = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        tick_div = 8'd3;
        load_val = '0;
        ex(1, K_CNT, 0); ex(1, K_TICK, 0); ex(1, K_WRAP, 0);
        ex(1, K_AN, 2'b01); ex(1, K_SEG, 7'h3F); ex(1, K_DP, 0);
        rst_cyc();

        // basic up count, tick period 4, scan every 4 cycles
        rst = 0; ena = 1; tick_div = 8'd3; mode = 2'b00;
        ex(1, K_TICK, 0); ex(3, K_CNT, 8'h00); ex(4, K_TICK, 1); ex(4, K_CNT, 8'h01);
        ex(4, K_WRAP, 0); ex(4, K_AN, 2'b01); ex(5, K_TICK, 0); ex(5, K_AN, 2'b10);
        ex(6, K_SEG, 7'h3F); ex(8, K_CNT, 8'h02); ex(9, K_AN, 2'b01); ex(9, K_SEG, 7'h5B);
        ex(12, K_CNT, 8'h03); ex(12, K_WRAP, 0);
        repeat (13) @(negedge clk);

        // roll-over up and down
        rst_cyc();
        rst = 0; load = 1; load_val = 8'h99; tick_div = 8'd3;
        ex(1, K_CNT, 8'h99);
        @(negedge clk);
        load = 0; ena = 1;
        ex(1, K_CNT, 8'h99); ex(1, K_WRAP, 0); ex(3, K_CNT, 8'h99); ex(4, K_CNT, 8'h00);
        ex(4, K_WRAP, 1); ex(4, K_TICK, 1); ex(5, K_WRAP, 0); ex(5, K_CNT, 8'h00);
        repeat (5) @(negedge clk);
        load = 1; load_val = 8'h00; mode = 2'b01;
        ex(1, K_CNT, 8'h00); ex(1, K_WRAP, 0);
        @(negedge clk);
        load = 0;
        ex(2, K_CNT, 8'h99); ex(2, K_WRAP, 1); ex(3, K_WRAP, 0);
        repeat (3) @(negedge clk);

        // load coincident with tick, saturated nibble
        rst_cyc();
        rst = 0; ena = 1; tick_div = 8'd3;
        repeat (3) @(negedge clk);
        load = 1; load_val = 8'hA5;
        ex(1, K_CNT, 8'h95); ex(1, K_TICK, 1); ex(1, K_WRAP, 0);
        @(negedge clk);
        load = 0;
        ex(1, K_TICK, 0); ex(4, K_TICK, 1); ex(4, K_CNT, 8'h96);
        repeat (4) @(negedge clk);

        // hold mode with display scan and dp
        rst_cyc();
        rst = 0; load = 1; load_val = 8'h42; mode = 2'b10; ena = 1; tick_div = 8'd5;
        ex(1, K_CNT, 8'h42); ex(2, K_AN, 2'b01); ex(2, K_SEG, 7'h5B); ex(2, K_DP, 0);
        ex(5, K_AN, 2'b10); ex(5, K_SEG, 7'h66); ex(6, K_TICK, 1); ex(6, K_CNT, 8'h42);
        ex(6, K_WRAP, 0); ex(7, K_DP, 0); ex(10, K_AN, 2'b01); ex(10, K_SEG, 7'h5B);
        ex(10, K_DP, 1); ex(13, K_AN, 2'b10); ex(13, K_SEG, 7'h66); ex(13, K_DP, 0);
        ex(17, K_DP, 0); ex(17, K_AN, 2'b01); ex(18, K_TICK, 1); ex(19, K_DP, 1);
        ex(19, K_CNT, 8'h42);
        @(negedge clk);
        load = 0;
        repeat (19) @(negedge clk);

        // shrinking tick_div, then ena gap
        rst_cyc();
        rst = 0; ena = 1; tick_div = 8'd100;
        ex(50, K_TICK, 0); ex(50, K_CNT, 8'h00);
        repeat (50) @(negedge clk);
        tick_div = 8'd10;
        ex(1, K_TICK, 1); ex(1, K_CNT, 8'h01); ex(2, K_TICK, 0); ex(11, K_TICK, 0);
        ex(12, K_TICK, 1); ex(12, K_CNT, 8'h02);
        repeat (14) @(negedge clk);
        ena = 0;
        ex(1, K_TICK, 0); ex(1, K_AN, 2'b01); ex(5, K_AN, 2'b10); ex(10, K_TICK, 0);
        ex(20, K_TICK, 0); ex(20, K_CNT, 8'h02);
        repeat (20) @(negedge clk);
        ena = 1;
        ex(8, K_TICK, 0); ex(9, K_TICK, 1); ex(9, K_CNT, 8'h03);
        repeat (10) @(negedge clk);

        // clear mode, then reset mid-scan
        rst_cyc();
        rst = 0; load = 1; load_val = 8'h37; ena = 1; tick_div = 8'd1;
        ex(1, K_CNT, 8'h37);
        @(negedge clk);
        load = 0; mode = 2'b11;
        ex(1, K_CNT, 8'h00); ex(1, K_TICK, 1); ex(1, K_WRAP, 0); ex(2, K_TICK, 0);
        ex(3, K_TICK, 1); ex(3, K_CNT, 8'h00);
        repeat (3) @(negedge clk);
        mode = 2'b00;
        ex(2, K_CNT, 8'h01); ex(3, K_AN, 2'b10);
        repeat (3) @(negedge clk);
        rst = 1;
        ex(1, K_CNT, 8'h00); ex(1, K_AN, 2'b01); ex(1, K_SEG, 7'h3F); ex(1, K_TICK, 0);
        ex(1, K_DP, 0);
        @(negedge clk);
        rst = 0;
        ex(1, K_TICK, 0); ex(2, K_TICK, 1); ex(2, K_CNT, 8'h01);
        repeat (3) @(negedge clk);

        repeat (2) @(negedge clk);
        foreach (sbq[i]) begin
            total++;
            bad++;
            $display("FAIL %s never checked cyc=%0d want=%0h", kname(sbq[i].kind), sbq[i].cyc, sbq[i].v);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
